// File: rtl/tx_arbiter.sv
// Round-robin arbiter that shares one parallel-load serial transmitter among N_REQ requesters.
// Define TX_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-wins priority.
module tx_arbiter #(
   parameter int N_REQ        = 4,
   parameter int DATA_W       = 4,
   parameter int FRAME_CYCLES = 6
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ*DATA_W-1:0]   req_data,
   output logic [N_REQ-1:0]          ack,
   output logic [$clog2(N_REQ)-1:0]  grant_id,
   output logic                      busy,
   output logic                      st,
   output logic [DATA_W-1:0]         data_in
);

   localparam int IDW = $clog2(N_REQ);
   localparam int CW  = $clog2(FRAME_CYCLES) + 1;

   typedef enum logic [1:0] {IDLE, START, WAIT} state_e;

   state_e              state_q;
   logic [CW-1:0]       cnt_q;
   logic [N_REQ-1:0]    ack_q;
   logic [IDW-1:0]      grant_q;
   logic [DATA_W-1:0]   data_q;

   logic                found_d;
   logic [IDW-1:0]      grant_d;
   logic [DATA_W-1:0]   data_d;

   // Winner selection; grant_q doubles as the round-robin pointer in the default build.
   always_comb begin
      found_d = 1'b0;
      grant_d = grant_q;
`ifdef TX_ARB_FIXED_PRIO_EN
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            found_d = 1'b1;
            grant_d = IDW'(i);
         end
      end
`else
      for (int k = 1; k <= N_REQ; k++) begin
         logic [IDW-1:0] idx;
         idx = IDW'((int'(grant_q) + k) % N_REQ);
         if (!found_d && req[idx]) begin
            found_d = 1'b1;
            grant_d = idx;
         end
      end
`endif
      data_d = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_d == IDW'(i)) begin
            data_d = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ack_q   <= '0;
         grant_q <= IDW'(N_REQ - 1);
         data_q  <= '0;
      end else begin
         ack_q <= '0;
         unique case (state_q)
            IDLE: begin
               if (found_d) begin
                  data_q  <= data_d;
                  grant_q <= grant_d;
                  ack_q   <= {{(N_REQ-1){1'b0}}, 1'b1} << grant_d;
                  state_q <= START;
               end
            end
            START: begin
               cnt_q   <= CW'(FRAME_CYCLES - 1);
               state_q <= WAIT;
            end
            WAIT: begin
               // The counter reaching zero ends the frame; it never wraps below zero.
               if (cnt_q == '0) begin
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign st       = (state_q == START);
   assign busy     = (state_q != IDLE);
   assign ack      = ack_q;
   assign grant_id = grant_q;
   assign data_in  = data_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Self-checking bench for tx_arbiter: a grant-level reference model compared every cycle,
// plus directed scenarios with hand-computed grant orders, spacings and reset values.
module tb_tx_arbiter;

   localparam int N = 4;
   localparam int W = 4;
   localparam int F = 6;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic [N-1:0]     req = '0;
   logic [N*W-1:0]   req_data = '0;
   logic [N-1:0]     ack;
   logic [1:0]       grant_id;
   logic             busy;
   logic             st;
   logic [W-1:0]     data_in;

   int checks = 0;
   int passes = 0;
   bit checkEn = 1'b0;
   int cycle = 0;

   int grantQ[$];
   int dataQ[$];
   int stCycles[$];
   int ackCount[N];

   // Model state: remaining busy cycles after a grant, pointer, and expected outputs.
   int            mBusyLeft;
   int            mPtr;
   logic [N-1:0]  eAck;
   logic          eSt;
   logic [W-1:0]  eData;
   logic [1:0]    eGrant;

   tx_arbiter #(.N_REQ(N), .DATA_W(W), .FRAME_CYCLES(F)) dut (
      .clk(clk), .reset(reset), .req(req), .req_data(req_data),
      .ack(ack), .grant_id(grant_id), .busy(busy), .st(st), .data_in(data_in)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   function automatic int pickWinner(input logic [N-1:0] r, input int ptr);
      int w;
      w = -1;
`ifdef TX_ARB_FIXED_PRIO_EN
      for (int i = N - 1; i >= 0; i--) if (r[i]) w = i;
`else
      for (int k = N; k >= 1; k--) if (r[(ptr + k) % N]) w = (ptr + k) % N;
`endif
      return w;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mBusyLeft <= 0;
         mPtr      <= N - 1;
         eAck      <= '0;
         eSt       <= 1'b0;
         eData     <= '0;
         eGrant    <= 2'(N - 1);
      end else if (mBusyLeft == 0 && req != '0) begin
         int w;
         w = pickWinner(req, mPtr);
         eAck      <= N'(1) << w;
         eSt       <= 1'b1;
         eData     <= req_data[w*W +: W];
         eGrant    <= 2'(w);
         mPtr      <= w;
         mBusyLeft <= F + 1;
      end else begin
         eAck <= '0;
         eSt  <= 1'b0;
         if (mBusyLeft > 0) mBusyLeft <= mBusyLeft - 1;
      end
   end

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      else passes++;
   endtask

   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("ack", int'(ack), int'(eAck));
         checkOutput("st", int'(st), int'(eSt));
         checkOutput("busy", int'(busy), int'(mBusyLeft > 0));
         checkOutput("data_in", int'(data_in), int'(eData));
         checkOutput("grant_id", int'(grant_id), int'(eGrant));
      end
   end

   always @(negedge clk) begin
      if (ack != '0) begin
         for (int i = 0; i < N; i++) if (ack[i]) ackCount[i]++;
         grantQ.push_back(int'(grant_id));
         dataQ.push_back(int'(data_in));
      end
      if (st) stCycles.push_back(cycle);
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [N-1:0] r, input logic [N*W-1:0] d);
      req      = r;
      req_data = d;
   endtask

   task automatic clearRecords();
      grantQ.delete();
      dataQ.delete();
      stCycles.delete();
      for (int i = 0; i < N; i++) ackCount[i] = 0;
   endtask

   task automatic pulseReset();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
   endtask

   task automatic waitGrants(input int n, input int maxCyc);
      int c;
      c = 0;
      while (grantQ.size() < n && c < maxCyc) begin
         tick();
         c++;
      end
      checkOutput("grantsSeen", grantQ.size() >= n ? n : grantQ.size(), n);
   endtask

   task automatic drainRequests(input int maxCyc);
      int c;
      c = 0;
      while ((req != '0 || busy) && c < maxCyc) begin
         tick();
         req = req & ~ack;
         c++;
      end
      checkOutput("drained", int'(req != '0 || busy), 0);
   endtask

   initial begin
      int n;
      applyStimulus('0, '0);
      repeat (3) tick();
      checkEn = 1'b1;
      reset = 1'b1;

      repeat (20) tick();
      checkOutput("idleSt", int'(st), 0);
      checkOutput("idleBusy", int'(busy), 0);
      checkOutput("idleData", int'(data_in), 0);
      checkOutput("idleGrant", int'(grant_id), 3);

      // Single request from requester 0.
      clearRecords();
      applyStimulus(4'b0001, 16'h0007);
      tick();
      checkOutput("singleAck", int'(ack), 1);
      checkOutput("singleSt", int'(st), 1);
      checkOutput("singleData", int'(data_in), 7);
      applyStimulus('0, 16'h0007);
      n = 1;
      for (int c = 0; c < 50; c++) begin
         tick();
         if (!busy) break;
         n++;
      end
      checkOutput("singleBusyLen", n, 1 + F);
      checkOutput("singleAckCount", ackCount[0], 1);

`ifndef TX_ARB_FIXED_PRIO_EN
      // All four requesting continuously: strict rotation from requester 0.
      pulseReset();
      clearRecords();
      applyStimulus(4'b1111, 16'hC953);
      waitGrants(5, 100);
      if (grantQ.size() >= 5 && stCycles.size() >= 5) begin
         int expOrder[5] = '{0, 1, 2, 3, 0};
         int expData[5]  = '{3, 5, 9, 12, 3};
         for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("rrOrder%0d", i), grantQ[i], expOrder[i]);
            checkOutput($sformatf("rrData%0d", i), dataQ[i], expData[i]);
         end
         for (int i = 1; i < 5; i++)
            checkOutput($sformatf("stSpacing%0d", i), stCycles[i] - stCycles[i-1], 8);
      end
      applyStimulus('0, 16'hC953);
      drainRequests(100);
`endif

      // Requesters 1 and 3 arrive while requester 0's frame is in flight.
      pulseReset();
      clearRecords();
      applyStimulus(4'b0001, 16'hA061);
      waitGrants(1, 20);
      req = 4'b1010;
      drainRequests(100);
      checkOutput("lateCount", grantQ.size(), 3);
      if (grantQ.size() == 3) begin
         checkOutput("lateOrder0", grantQ[0], 0);
         checkOutput("lateOrder1", grantQ[1], 1);
         checkOutput("lateOrder2", grantQ[2], 3);
         checkOutput("lateData1", dataQ[1], 6);
         checkOutput("lateData2", dataQ[2], 10);
      end
      checkOutput("lateAck0", ackCount[0], 1);
      checkOutput("lateAck1", ackCount[1], 1);
      checkOutput("lateAck2", ackCount[2], 0);
      checkOutput("lateAck3", ackCount[3], 1);

      // Reset asserted in the middle of WAIT.
      clearRecords();
      applyStimulus(4'b0001, 16'h000B);
      waitGrants(1, 20);
      req = '0;
      repeat (3) tick();
      checkOutput("midBusy", int'(busy), 1);
      reset = 1'b0;
      #1;
      checkOutput("rstBusy", int'(busy), 0);
      checkOutput("rstSt", int'(st), 0);
      checkOutput("rstAck", int'(ack), 0);
      checkOutput("rstData", int'(data_in), 0);
      checkOutput("rstGrant", int'(grant_id), 3);
      repeat (2) tick();
      reset = 1'b1;
      clearRecords();
      applyStimulus(4'b0011, 16'h0042);
      waitGrants(1, 20);
      if (grantQ.size() >= 1) checkOutput("postRstFirst", grantQ[0], 0);
      req = '0;
      drainRequests(100);

`ifdef TX_ARB_FIXED_PRIO_EN
      // Fixed priority: requester 1 dominates until it drops.
      pulseReset();
      clearRecords();
      applyStimulus(4'b1010, 16'hD0E0);
      waitGrants(3, 100);
      for (int i = 0; i < 3 && i < grantQ.size(); i++)
         checkOutput($sformatf("fixOrder%0d", i), grantQ[i], 1);
      req = 4'b1000;
      waitGrants(4, 100);
      if (grantQ.size() >= 4) checkOutput("fixAfterDrop", grantQ[3], 3);
      req = '0;
      drainRequests(100);
`endif

      checkEn = 1'b0;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/tx_arbiter.md
# tx_arbiter

Round-robin arbiter and sequencer that shares one 4-bit parallel-load serial transmitter (`st`/`data_in` → `tx`) among `N_REQ` requesters. It picks one pending requester and latches its word onto `data_in`. It then pulses `st` to launch the frame and holds off further grants until the frame time `FRAME_CYCLES` has elapsed. The block sits between client logic and the serializer and is the only driver of the serializer's `st` and `data_in`.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `DATA_W`, default 4: word width, matches the serializer's `data_in`.
- `FRAME_CYCLES`, default 6: clk cycles the serializer needs after `st` before it can accept the next `st`; must be ≥1.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  per-requester request level.
- `req_data`  in  N_REQ*DATA_W  requester i's word is in bits [i*DATA_W +: DATA_W].
- `ack`  out  N_REQ  one-cycle pulse; the word of requester i has been latched.
- `grant_id`  out  $clog2(N_REQ)  index of the last granted requester.
- `busy`  out  1  high whenever the state is not IDLE.
- `st`  out  1  one-cycle start pulse to the serializer.
- `data_in`  out  DATA_W  word presented to the serializer.

## Operation
- **FSM states:** IDLE, START, WAIT.
- **IDLE:**
  - If any `req` bit is set, select a winner per the arbitration rule.
  - Register `data_in` ← winner's word, `grant_id` ← winner, `ack[winner]` ← 1.
  - Go to START.
  - With no request, stay in IDLE; outputs hold.
- **START:**
  - `st` = 1, decoded from the state.
  - Load counter with FRAME_CYCLES-1.
  - Go to WAIT.
- **WAIT:**
  - If counter == 0, go to IDLE.
  - Otherwise decrement.
- **Arbitration:**
  - Round-robin; search starts at `grant_id`+1 and wraps modulo N_REQ.
  - The round-robin pointer is `grant_id`; its reset value is N_REQ-1, so requester 0 wins first after reset.
- **Request sampling:**
  - `req` is sampled only in IDLE.
  - A requester holds `req` and its `req_data` stable until it sees `ack`.
  - A `req` still high when IDLE is re-entered is treated as a new word.
- **`data_in`:** holds the last granted word until the next grant; it never changes while `busy` = 1.
- **Reset values:**
  - `st`=0, `ack`=0, `busy`=0, `data_in`=0.
  - `grant_id`=N_REQ-1.
  - State = IDLE, counter = 0.
- **Reset mid-frame:**
  - All outputs go to their reset values immediately (asynchronous).
  - No `ack` is issued for any word that was not yet latched.
- **Counter width:** $clog2(FRAME_CYCLES)+1 bits; no wrap occurs.

## Timing
- **Grant latency:** `req` seen in IDLE at edge t → `ack`, `st`, new `data_in`, `busy`=1 during cycle t+1.
- **WAIT duration:** FRAME_CYCLES cycles (t+2 .. t+1+FRAME_CYCLES); IDLE is re-entered at cycle t+2+FRAME_CYCLES.
- **Back-to-back `st` spacing:** FRAME_CYCLES+2 cycles under continuous requests.
- **Pulse widths:** `ack` and `st` are exactly one cycle each and coincide.
- **Simultaneous requests:** exactly one `ack` per grant; losers keep waiting with no loss.
- **Starvation bound:** a continuously asserted requester is granted within N_REQ grants.

## Configuration
- **`TX_ARB_FIXED_PRIO_EN` defined:**
  - Fixed priority; the lowest asserted index always wins.
  - `grant_id` still reports the winner but is not used as a pointer.
- **Undefined (default):** round-robin as described above.
- All other behaviour and timing are identical in both builds.

## Test plan
- Reset release, `req`=0 for 20 cycles → `st`=0, `busy`=0, `data_in`=0, `grant_id`=3.
- Single request: `req`=4'b0001, word 4'b0111 → `ack[0]` and `st` one cycle after sampling, `data_in`=4'b0111, `busy` for 1+FRAME_CYCLES cycles, then IDLE.
- All four requesting continuously with distinct words → grants in order 0,1,2,3,0; `st` spacing = 8 cycles at FRAME_CYCLES=6.
- Requests from 1 and 3 while busy with 0 → next grant is 1, then 3; no word lost; each `ack` exactly once.
- `reset` asserted low in WAIT, counter mid-count → outputs immediately at reset values; after release, requester 0 is granted first.
- With `TX_ARB_FIXED_PRIO_EN` defined and `req`=4'b1010 held → requester 1 is granted repeatedly; requester 3 is granted only after `req[1]` drops.
